// File: rtl/alu_issue_if.sv
// alu_issue_if: shared ALU types plus the request, ALU and writeback bus of the issue stage.
package alu_issue_pkg;
  typedef enum logic [3:0] {
    ALU_OP_ADD, ALU_OP_ADC, ALU_OP_SUB, ALU_OP_SBB, ALU_OP_AND, ALU_OP_OR,
    ALU_OP_XOR, ALU_OP_CMP, ALU_OP_TEST1, ALU_OP_SHL, ALU_OP_SHR, ALU_OP_INC,
    ALU_OP_DEC, ALU_OP_NOT, ALU_OP_NEG, ALU_OP_NOP
  } alu_operation_e;
  typedef struct packed {
    logic cy;
    logic z;
    logic s;
    logic ov;
  } flags_t;
endpackage

interface alu_issue_if;
  logic                          req_valid;
  logic                          req_ready;
  alu_issue_pkg::alu_operation_e req_op;
  logic [15:0]                   req_ta;
  logic [15:0]                   req_tb;
  logic                          req_wide;
  logic [2:0]                    req_dst;
  alu_issue_pkg::flags_t         flags_cur;
  alu_issue_pkg::alu_operation_e alu_operation;
  logic [15:0]                   alu_ta;
  logic [15:0]                   alu_tb;
  logic                          alu_wide;
  alu_issue_pkg::flags_t         alu_flags_in;
  logic                          alu_execute;
  logic                          alu_busy;
  logic [15:0]                   alu_result;
  alu_issue_pkg::flags_t         alu_flags;
  logic                          wb_valid;
  logic                          wb_ack;
  logic [15:0]                   wb_result;
  logic [2:0]                    wb_dst;
  logic                          wb_write_reg;
  alu_issue_pkg::flags_t         wb_flags;
  logic                          err_timeout;
  modport master (
    output req_valid, req_op, req_ta, req_tb, req_wide, req_dst, flags_cur,
           alu_busy, alu_result, alu_flags, wb_ack,
    input  req_ready, alu_operation, alu_ta, alu_tb, alu_wide, alu_flags_in,
           alu_execute, wb_valid, wb_result, wb_dst, wb_write_reg, wb_flags, err_timeout
  );
  modport slave (
    input  req_valid, req_op, req_ta, req_tb, req_wide, req_dst, flags_cur,
           alu_busy, alu_result, alu_flags, wb_ack,
    output req_ready, alu_operation, alu_ta, alu_tb, alu_wide, alu_flags_in,
           alu_execute, wb_valid, wb_result, wb_dst, wb_write_reg, wb_flags, err_timeout
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: accepts one decoded op, issues it to the ALU, waits for completion
// with a timeout, then holds the result for writeback until acknowledged.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     ce,
  alu_issue_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_e;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          expire;
  always_comb begin
    expire   = state == WAIT && bus.alu_busy && cnt == CW'(TIMEOUT - 1);
    state_nx = state == IDLE  ? (bus.req_valid ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (!bus.alu_busy ? WB : expire ? IDLE : WAIT) :
               (bus.wb_ack ? IDLE : WB);
    cnt_nx   = state == ISSUE ? '0 :
               (state == WAIT && bus.alu_busy && !expire) ? cnt + 1'b1 : cnt;
  end
  // Handshake strobes decode straight from state so an async reset drops them at once.
  assign bus.req_ready   = state == IDLE;
  assign bus.alu_execute = state == ISSUE;
  assign bus.wb_valid    = state == WB;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      bus.err_timeout   <= 1'b0;
      bus.alu_operation <= ALU_OP_ADD;
      bus.alu_ta        <= '0;
      bus.alu_tb        <= '0;
      bus.alu_wide      <= 1'b0;
      bus.alu_flags_in  <= '0;
      bus.wb_result     <= '0;
      bus.wb_flags      <= '0;
      bus.wb_dst        <= '0;
      bus.wb_write_reg  <= 1'b0;
    end else if (ce) begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      bus.err_timeout <= expire;
      if (state == IDLE && bus.req_valid) begin
        bus.alu_operation <= bus.req_op;
        bus.alu_ta        <= bus.req_ta;
        bus.alu_tb        <= bus.req_tb;
        bus.alu_wide      <= bus.req_wide;
        bus.alu_flags_in  <= bus.flags_cur;
        bus.wb_dst        <= bus.req_dst;
        bus.wb_write_reg  <= !(bus.req_op == ALU_OP_CMP || bus.req_op == ALU_OP_TEST1);
      end
      if (state == WAIT && !bus.alu_busy) begin
        bus.wb_result <= bus.alu_result;
        bus.wb_flags  <= bus.alu_flags;
      end
    end
  end
endmodule
